// File: rtl/time_keeper.sv
// BCD hh:mm:ss time-of-day counter advanced by a 1 Hz strobe.
// Supports validated time-set loads, run/pause, and minute/hour/day carry pulses.
module time_keeper #(
  parameter bit TWELVE_HR = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       load_pm,
  output logic       load_ack,
  output logic       load_err,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_tick
);

  localparam logic [7:0] HR_RESET = TWELVE_HR ? 8'h12 : 8'h00;

  logic [7:0] hr_reg, hr_next;
  logic [7:0] min_reg, min_next;
  logic [7:0] sec_reg, sec_next;
  logic       pm_reg, pm_next;
  logic       ack_reg, ack_next;
  logic       err_reg, err_next;
  logic       min_tick_reg, min_tick_next;
  logic       hour_tick_reg, hour_tick_next;
  logic       day_tick_reg, day_tick_next;

  logic [23:0] load_fields;
  logic [5:0]  digit_ok;
  logic        hr_ok;
  logic        load_valid;
  logic        advance;

  assign load_fields = {load_hh, load_mm, load_ss};

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit
      assign digit_ok[gi] = (load_fields[gi*4 +: 4] <= 4'd9);
    end
  endgenerate

  // With all digits valid, BCD bytes compare correctly as plain binary.
  assign hr_ok = TWELVE_HR ? ((load_hh >= 8'h01) && (load_hh <= 8'h12))
                           : (load_hh <= 8'h23);
  assign load_valid = (&digit_ok) && (load_mm <= 8'h59) && (load_ss <= 8'h59) && hr_ok;
  assign advance    = tick_1s && run && !load;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    hr_next        = hr_reg;
    min_next       = min_reg;
    sec_next       = sec_reg;
    pm_next        = pm_reg;
    ack_next       = 1'b0;
    err_next       = 1'b0;
    min_tick_next  = 1'b0;
    hour_tick_next = 1'b0;
    day_tick_next  = 1'b0;

    if (load) begin
      if (load_valid) begin
        hr_next  = load_hh;
        min_next = load_mm;
        sec_next = load_ss;
        pm_next  = TWELVE_HR ? load_pm : 1'b0;
        ack_next = 1'b1;
      end else begin
        err_next = 1'b1;
      end
    end else if (advance) begin
      if (sec_reg == 8'h59) begin
        sec_next      = 8'h00;
        min_tick_next = 1'b1;
        if (min_reg == 8'h59) begin
          min_next       = 8'h00;
          hour_tick_next = 1'b1;
          if (TWELVE_HR) begin
            // 12 -> 01 keeps the meridiem; 11 -> 12 flips it, and PM -> AM is midnight.
            if (hr_reg == 8'h12) begin
              hr_next = 8'h01;
            end else if (hr_reg == 8'h11) begin
              hr_next       = 8'h12;
              pm_next       = !pm_reg;
              day_tick_next = pm_reg;
            end else begin
              hr_next = bcd_inc(hr_reg);
            end
          end else begin
            if (hr_reg == 8'h23) begin
              hr_next       = 8'h00;
              day_tick_next = 1'b1;
            end else begin
              hr_next = bcd_inc(hr_reg);
            end
          end
        end else begin
          min_next = bcd_inc(min_reg);
        end
      end else begin
        sec_next = bcd_inc(sec_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hr_reg        <= HR_RESET;
      min_reg       <= 8'h00;
      sec_reg       <= 8'h00;
      pm_reg        <= 1'b0;
      ack_reg       <= 1'b0;
      err_reg       <= 1'b0;
      min_tick_reg  <= 1'b0;
      hour_tick_reg <= 1'b0;
      day_tick_reg  <= 1'b0;
    end else begin
      hr_reg        <= hr_next;
      min_reg       <= min_next;
      sec_reg       <= sec_next;
      pm_reg        <= pm_next;
      ack_reg       <= ack_next;
      err_reg       <= err_next;
      min_tick_reg  <= min_tick_next;
      hour_tick_reg <= hour_tick_next;
      day_tick_reg  <= day_tick_next;
    end
  end

  assign hr_bcd    = hr_reg;
  assign min_bcd   = min_reg;
  assign sec_bcd   = sec_reg;
  assign pm        = pm_reg;
  assign load_ack  = ack_reg;
  assign load_err  = err_reg;
  assign min_tick  = min_tick_reg;
  assign hour_tick = hour_tick_reg;
  assign day_tick  = day_tick_reg;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: one 24-hour and one 12-hour instance share stimulus.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1s = 1'b0;
  logic       run = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_hh = 8'h00;
  logic [7:0] load_mm = 8'h00;
  logic [7:0] load_ss = 8'h00;
  logic       load_pm = 1'b0;

  logic       a_ack, a_err, a_pm, a_mt, a_ht, a_dt;
  logic [7:0] a_hr, a_min, a_sec;
  logic       b_ack, b_err, b_pm, b_mt, b_ht, b_dt;
  logic [7:0] b_hr, b_min, b_sec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  time_keeper #(.TWELVE_HR(1'b0)) u24 (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .run(run), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
    .load_ack(a_ack), .load_err(a_err), .hr_bcd(a_hr), .min_bcd(a_min), .sec_bcd(a_sec),
    .pm(a_pm), .min_tick(a_mt), .hour_tick(a_ht), .day_tick(a_dt)
  );

  time_keeper #(.TWELVE_HR(1'b1)) u12 (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .run(run), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
    .load_ack(b_ack), .load_err(b_err), .hr_bcd(b_hr), .min_bcd(b_min), .sec_bcd(b_sec),
    .pm(b_pm), .min_tick(b_mt), .hour_tick(b_ht), .day_tick(b_dt)
  );

  // Apply inputs at the falling edge, return 1 time unit after the next rising edge.
  task automatic cyc(input logic t, input logic r, input logic l, input logic rs);
    @(negedge clk);
    tick_1s = t; run = r; load = l; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [7:0] hh, input logic [7:0] mm,
                            input logic [7:0] ss, input logic p);
    load_hh = hh; load_mm = mm; load_ss = ss; load_pm = p;
  endtask

  task automatic test_reset;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({a_hr, a_min, a_sec} !== 24'h000000) begin
      errors++; $display("FAIL reset_24 got=%h want=000000", {a_hr, a_min, a_sec});
    end
    checks++;
    if ({b_hr, b_min, b_sec, 7'd0, b_pm} !== {24'h120000, 8'h00}) begin
      errors++; $display("FAIL reset_12 got=%h pm=%b want=120000 pm=0", {b_hr, b_min, b_sec}, b_pm);
    end
    checks++;
    if ({a_ack, a_err, a_mt, a_ht, a_dt, b_ack, b_err, b_mt, b_ht, b_dt} !== 10'd0) begin
      errors++; $display("FAIL reset_pulses got=%b want=0", {a_ack, a_err, a_mt, a_ht, a_dt, b_ack, b_err, b_mt, b_ht, b_dt});
    end
    $display("reset done: 24h=%h 12h=%h", {a_hr, a_min, a_sec}, {b_hr, b_min, b_sec});
  endtask

  task automatic test_sixty_ticks;
    int mt_count = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      if (a_mt) begin
        mt_count++;
        checks++;
        if (a_sec !== 8'h00) begin
          errors++; $display("FAIL min_tick_align sec=%h want=00", a_sec);
        end
      end
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    if (a_mt) mt_count++;
    checks++;
    if (mt_count !== 1) begin
      errors++; $display("FAIL min_tick_count got=%0d want=1", mt_count);
    end
    checks++;
    if ({a_hr, a_min, a_sec} !== 24'h000100) begin
      errors++; $display("FAIL sixty_ticks got=%h want=000100", {a_hr, a_min, a_sec});
    end
    $display("60 ticks: 24h=%h min_ticks=%0d", {a_hr, a_min, a_sec}, mt_count);
  endtask

  task automatic test_midnight_24;
    set_fields(8'h23, 8'h59, 8'h59, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({a_ack, a_err} !== 2'b10) begin
      errors++; $display("FAIL load_235959_ack got=%b want=10", {a_ack, a_err});
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({a_hr, a_min, a_sec, a_mt, a_ht, a_dt} !== {24'h000000, 3'b111}) begin
      errors++; $display("FAIL midnight_24 got=%h pulses=%b want=000000 111", {a_hr, a_min, a_sec}, {a_mt, a_ht, a_dt});
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({a_mt, a_ht, a_dt} !== 3'b000) begin
      errors++; $display("FAIL midnight_pulse_width got=%b want=000", {a_mt, a_ht, a_dt});
    end
    $display("midnight 24h: %h", {a_hr, a_min, a_sec});
  endtask

  task automatic test_twelve_hour;
    set_fields(8'h11, 8'h59, 8'h59, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({b_hr, b_min, b_sec, b_pm, b_ht, b_dt} !== {24'h120000, 3'b110}) begin
      errors++; $display("FAIL noon_12 got=%h pm=%b ht=%b dt=%b want=120000 pm=1 ht=1 dt=0", {b_hr, b_min, b_sec}, b_pm, b_ht, b_dt);
    end
    set_fields(8'h12, 8'h59, 8'h59, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({b_hr, b_min, b_sec, b_pm, b_dt} !== {24'h010000, 2'b10}) begin
      errors++; $display("FAIL one_pm_12 got=%h pm=%b dt=%b want=010000 pm=1 dt=0", {b_hr, b_min, b_sec}, b_pm, b_dt);
    end
    set_fields(8'h11, 8'h59, 8'h59, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({b_hr, b_min, b_sec, b_pm, b_mt, b_ht, b_dt} !== {24'h120000, 4'b0111}) begin
      errors++; $display("FAIL midnight_12 got=%h pm=%b pulses=%b want=120000 pm=0 111", {b_hr, b_min, b_sec}, b_pm, {b_mt, b_ht, b_dt});
    end
    $display("12h sequence done: %h pm=%b", {b_hr, b_min, b_sec}, b_pm);
  endtask

  task automatic test_load_validation;
    // Entering: 24h instance shows 12:00:00, 12h instance shows 12:00:00 AM.
    set_fields(8'h24, 8'h00, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({a_ack, a_err, a_hr, a_min, a_sec} !== {2'b01, 24'h120000}) begin
      errors++; $display("FAIL load_24h_hr24 ack/err=%b time=%h want=01 120000", {a_ack, a_err}, {a_hr, a_min, a_sec});
    end
    set_fields(8'h00, 8'h30, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({b_ack, b_err, b_hr, b_min, b_sec} !== {2'b01, 24'h120000}) begin
      errors++; $display("FAIL load_12h_hr00 ack/err=%b time=%h want=01 120000", {b_ack, b_err}, {b_hr, b_min, b_sec});
    end
    checks++;
    if ({a_ack, a_err, a_hr, a_min, a_sec} !== {2'b10, 24'h003000}) begin
      errors++; $display("FAIL load_24h_hr00 ack/err=%b time=%h want=10 003000", {a_ack, a_err}, {a_hr, a_min, a_sec});
    end
    set_fields(8'h12, 8'h5A, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({a_ack, a_err, a_hr, a_min, a_sec} !== {2'b01, 24'h003000}) begin
      errors++; $display("FAIL load_bad_digit ack/err=%b time=%h want=01 003000", {a_ack, a_err}, {a_hr, a_min, a_sec});
    end
    set_fields(8'h12, 8'h34, 8'h56, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({a_ack, a_err, a_hr, a_min, a_sec} !== {2'b10, 24'h123456}) begin
      errors++; $display("FAIL load_123456 ack/err=%b time=%h want=10 123456", {a_ack, a_err}, {a_hr, a_min, a_sec});
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({a_ack, a_err} !== 2'b00) begin
      errors++; $display("FAIL ack_pulse_width got=%b want=00", {a_ack, a_err});
    end
    $display("load validation done: 24h=%h", {a_hr, a_min, a_sec});
  endtask

  task automatic test_load_vs_tick_and_pause;
    set_fields(8'h08, 8'h15, 8'h30, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({a_hr, a_min, a_sec, a_mt} !== {24'h081530, 1'b0}) begin
      errors++; $display("FAIL load_beats_tick got=%h mt=%b want=081530 0", {a_hr, a_min, a_sec}, a_mt);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({a_hr, a_min, a_sec} !== 24'h081530) begin
      errors++; $display("FAIL tick_not_deferred got=%h want=081530", {a_hr, a_min, a_sec});
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({a_hr, a_min, a_sec} !== 24'h081530) begin
      errors++; $display("FAIL run0_hold got=%h want=081530", {a_hr, a_min, a_sec});
    end
    set_fields(8'h10, 8'h00, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({a_ack, a_hr, a_min, a_sec} !== {1'b1, 24'h100000}) begin
      errors++; $display("FAIL run0_load ack=%b time=%h want=1 100000", a_ack, {a_hr, a_min, a_sec});
    end
    $display("load/tick and pause done: 24h=%h", {a_hr, a_min, a_sec});
  endtask

  task automatic test_reset_mid_count;
    set_fields(8'h07, 8'h45, 8'h32, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({a_hr, a_min, a_sec} !== 24'h074533) begin
      errors++; $display("FAIL pre_reset got=%h want=074533", {a_hr, a_min, a_sec});
    end
    // Reset coincides with both a tick and a load request.
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({a_hr, a_min, a_sec, a_ack, a_err, a_mt, a_ht, a_dt} !== {24'h000000, 5'b00000}) begin
      errors++; $display("FAIL reset_mid_count got=%h pulses=%b want=000000 00000", {a_hr, a_min, a_sec}, {a_ack, a_err, a_mt, a_ht, a_dt});
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({a_hr, a_min, a_sec} !== 24'h000001) begin
      errors++; $display("FAIL resume_after_reset got=%h want=000001", {a_hr, a_min, a_sec});
    end
    $display("reset mid-count done: 24h=%h", {a_hr, a_min, a_sec});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_sixty_ticks;
    test_midnight_24;
    test_twelve_hour;
    test_load_validation;
    test_load_vs_tick_and_pause;
    test_reset_mid_count;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
